// File: rtl/cla_pkg.sv
// Shared constants and stage control bundle for the pipelined CLA adder.
// Data widths depend on parameters, so the data half of a stage lives in the top.
package cla_pkg;

   localparam int BLK_W = 4;

   typedef struct packed {
      logic valid;
      logic carry;
      logic ovf;
   } stage_ctl_t;

   function automatic int stages(input int width, input int gps);
      return width / (BLK_W * gps);
   endfunction

endpackage

// File: rtl/cla4_gp.sv
// Combinational 4-bit carry-lookahead group.
// Exports group generate/propagate and the carry into bit 3 for overflow.
module cla4_gp (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] s,
   output logic       g,
   output logic       p,
   output logic       c3
);

   logic [3:0] gi;
   logic [3:0] pi;
   logic [3:0] c;

   assign gi = a & b;
   assign pi = a ^ b;

   assign c[0] = cin;
   assign c[1] = gi[0] | (pi[0] & cin);
   assign c[2] = gi[1] | (pi[1] & gi[0])
               | (pi[1] & pi[0] & cin);
   assign c[3] = gi[2] | (pi[2] & gi[1])
               | (pi[2] & pi[1] & gi[0])
               | (pi[2] & pi[1] & pi[0] & cin);

   assign g = gi[3] | (pi[3] & gi[2])
            | (pi[3] & pi[2] & gi[1])
            | (pi[3] & pi[2] & pi[1] & gi[0]);
   assign p = &pi;

   assign s  = pi ^ c;
   assign c3 = c[3];

endmodule

// File: rtl/cla_adder_pipe.sv
// Pipelined carry-lookahead adder/subtractor with valid/ready on both sides.
// Each stage adds 4*GROUPS_PER_STAGE bits; the carry crosses stage registers.
module cla_adder_pipe
   import cla_pkg::*;
#(
   parameter int WIDTH            = 16,
   parameter int GROUPS_PER_STAGE = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             c_out,
   output logic             ovf
);

   localparam int GPS    = GROUPS_PER_STAGE;
   localparam int SW     = BLK_W * GPS;
   localparam int STAGES = stages(WIDTH, GPS);

   typedef struct packed {
      stage_ctl_t       ctl;
      logic [WIDTH-1:0] sum_lo;
      logic [WIDTH-1:0] a_hi;
      logic [WIDTH-1:0] b_hi;
   } stage_t;

   if ((WIDTH < BLK_W) || (WIDTH % SW != 0)) begin : g_bad_width
      $error("cla_adder_pipe: WIDTH must be a multiple of 4*GROUPS_PER_STAGE");
   end

   logic   en;
   stage_t pipe [STAGES+1];

   assign en       = !pipe[STAGES].ctl.valid || out_ready;
   assign in_ready = en;

   assign pipe[0] = '{
      ctl:    '{valid: in_valid, carry: sub ? 1'b1 : c_in, ovf: 1'b0},
      sum_lo: '0,
      a_hi:   a,
      b_hi:   sub ? ~b : b
   };

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      localparam int LO = k * SW;

      logic [GPS-1:0] gg;
      logic [GPS-1:0] pp;
      logic [GPS-1:0] c3v;
      logic [GPS:0]   gc;
      logic [SW-1:0]  s;
      logic           c3_unused;
      stage_t         prv;
      stage_t         stg_d;
      stage_t         stg_q;

      assign prv = pipe[k];

      for (genvar g = 0; g < GPS; g++) begin : g_grp
         cla4_gp u_grp (
            .a   (prv.a_hi[LO+g*BLK_W +: BLK_W]),
            .b   (prv.b_hi[LO+g*BLK_W +: BLK_W]),
            .cin (gc[g]),
            .s   (s[g*BLK_W +: BLK_W]),
            .g   (gg[g]),
            .p   (pp[g]),
            .c3  (c3v[g])
         );
      end

      // Flat sum-of-products per group carry: no ripple between groups.
      always_comb begin
         logic t;
         logic m;
         gc    = '0;
         gc[0] = prv.ctl.carry;
         for (int j = 1; j <= GPS; j++) begin
            t = prv.ctl.carry;
            for (int i = 0; i < j; i++) t = t & pp[i];
            for (int i = 0; i < j; i++) begin
               m = gg[i];
               for (int n = i + 1; n < j; n++) m = m & pp[n];
               t = t | m;
            end
            gc[j] = t;
         end
      end

      always_comb begin
         stg_d                  = prv;
         stg_d.sum_lo[LO +: SW] = s;
         stg_d.a_hi[LO +: SW]   = '0;
         stg_d.b_hi[LO +: SW]   = '0;
         stg_d.ctl.carry        = gc[GPS];
         stg_d.ctl.ovf          = c3v[GPS-1] ^ gc[GPS];
      end

      assign c3_unused = ^c3v;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            stg_q <= '0;
         end else if (en) begin
            stg_q <= stg_d;
         end
      end

      assign pipe[k+1] = stg_q;
   end

   assign out_valid = pipe[STAGES].ctl.valid;
   assign sum       = pipe[STAGES].sum_lo;
   assign c_out     = pipe[STAGES].ctl.carry;
   assign ovf       = pipe[STAGES].ctl.ovf;

endmodule

// File: tb/tb_cla_adder_pipe.sv
// Scoreboard bench: directed cases on a 16/1 instance, random traffic on a 32/2 one.
// Expected results come from plain integer arithmetic on the operands.
module tb_cla_adder_pipe;

   localparam int L1 = 4;

   typedef struct {
      logic [31:0] sum;
      logic        c;
      logic        v;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   int n2 = 0;

   logic        iv1, ir1, ov1, or1, ci1, sb1, co1, of1;
   logic [15:0] a1, b1, s1;
   logic        iv2, ir2, ov2, or2, ci2, sb2, co2, of2;
   logic [31:0] a2, b2, s2;

   exp_t q1[$];
   exp_t q2[$];

   cla_adder_pipe #(.WIDTH(16), .GROUPS_PER_STAGE(1)) u_d16 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(iv1), .in_ready(ir1),
      .a(a1), .b(b1), .c_in(ci1), .sub(sb1),
      .out_valid(ov1), .out_ready(or1),
      .sum(s1), .c_out(co1), .ovf(of1)
   );

   cla_adder_pipe #(.WIDTH(32), .GROUPS_PER_STAGE(2)) u_d32 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(iv2), .in_ready(ir2),
      .a(a2), .b(b2), .c_in(ci2), .sub(sb2),
      .out_valid(ov2), .out_ready(or2),
      .sum(s2), .c_out(co2), .ovf(of2)
   );

   function automatic exp_t model(input int w, input logic [31:0] a,
                                  input logic [31:0] b, input logic ci,
                                  input logic sb);
      longint lim, ua, ub, sa, sbv, r, sr;
      exp_t e;
      lim = longint'(1) << w;
      ua  = longint'(a);
      ub  = longint'(b);
      sa  = (ua >= lim / 2) ? ua - lim : ua;
      sbv = (ub >= lim / 2) ? ub - lim : ub;
      if (sb) begin
         r   = ua - ub;
         sr  = sa - sbv;
         e.c = (ua >= ub);
      end else begin
         r   = ua + ub + (ci ? 1 : 0);
         sr  = sa + sbv + (ci ? 1 : 0);
         e.c = (r >= lim);
      end
      e.sum = 32'(r & (lim - 1));
      e.v   = (sr >= lim / 2) || (sr < -(lim / 2));
      return e;
   endfunction

   function automatic logic [31:0] pick();
      logic [31:0] edge_v [5];
      edge_v = '{32'h0, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32'h1};
      if ($urandom_range(3) == 0) return edge_v[$urandom_range(4)];
      return $urandom;
   endfunction

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", nm, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (iv1 && ir1) q1.push_back(model(16, 32'(a1), 32'(b1), ci1, sb1));
         if (iv2 && ir2) begin
            q2.push_back(model(32, a2, b2, ci2, sb2));
            n2++;
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (rst_n && ov1 && or1) begin
         if (q1.size() == 0) begin
            check("sb16_empty", 32'(q1.size()), 32'd1);
         end else begin
            e = q1.pop_front();
            check("sum16", 32'(s1), e.sum);
            check("cout16", 32'(co1), 32'(e.c));
            check("ovf16", 32'(of1), 32'(e.v));
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (rst_n && ov2 && or2) begin
         if (q2.size() == 0) begin
            check("sb32_empty", 32'(q2.size()), 32'd1);
         end else begin
            e = q2.pop_front();
            check("sum32", s2, e.sum);
            check("cout32", 32'(co2), 32'(e.c));
            check("ovf32", 32'(of2), 32'(e.v));
         end
      end
   end

   task automatic op1(input logic [15:0] a, input logic [15:0] b,
                      input logic ci, input logic sb,
                      input logic [15:0] xs, input logic xc, input logic xv);
      int lat;
      iv1 = 1'b1; a1 = a; b1 = b; ci1 = ci; sb1 = sb;
      @(posedge clk); #1;
      iv1 = 1'b0;
      lat = 1;
      while (!ov1 && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      check("lat16", 32'(lat), 32'(L1));
      check("dir_sum16", 32'(s1), 32'(xs));
      check("dir_cout16", 32'(co1), 32'(xc));
      check("dir_ovf16", 32'(of1), 32'(xv));
      @(posedge clk); #1;
   endtask

   initial begin
      logic [15:0] hs;
      logic        hc, ho;
      iv1 = 0; a1 = 0; b1 = 0; ci1 = 0; sb1 = 0; or1 = 1;
      iv2 = 0; a2 = 0; b2 = 0; ci2 = 0; sb2 = 0; or2 = 1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_ov16", 32'(ov1), 32'd0);
      check("rst_sum16", 32'(s1), 32'd0);
      check("rst_cout16", 32'(co1), 32'd0);
      check("rst_ovf16", 32'(of1), 32'd0);
      check("rst_ir16", 32'(ir1), 32'd1);
      check("rst_ov32", 32'(ov2), 32'd0);
      check("rst_sum32", s2, 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      op1(16'h0004, 16'h0003, 1'b0, 1'b0, 16'h0007, 1'b0, 1'b0);
      op1(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0);
      op1(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
      op1(16'h0005, 16'h0006, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0);
      op1(16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1);

      or1 = 1'b0;
      for (int i = 0; i < 4; i++) begin
         iv1 = 1'b1;
         a1 = 16'($urandom); b1 = 16'($urandom);
         ci1 = 1'($urandom); sb1 = 1'($urandom);
         @(posedge clk); #1;
      end
      iv1 = 1'b0;
      for (int i = 0; i < 20 && !ov1; i++) begin
         @(posedge clk); #1;
      end
      check("stall_ov16", 32'(ov1), 32'd1);
      hs = s1; hc = co1; ho = of1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check("hold_sum16", 32'(s1), 32'(hs));
         check("hold_cout16", 32'(co1), 32'(hc));
         check("hold_ovf16", 32'(of1), 32'(ho));
         check("hold_ov16", 32'(ov1), 32'd1);
         check("hold_ir16", 32'(ir1), 32'd0);
      end
      or1 = 1'b1;
      for (int i = 0; i < 40 && q1.size() != 0; i++) begin
         @(posedge clk); #1;
      end
      check("drain16", 32'(q1.size()), 32'd0);

      for (int i = 0; i < 5; i++) begin
         iv1 = 1'b1;
         a1 = 16'($urandom); b1 = 16'($urandom);
         ci1 = 1'($urandom); sb1 = 1'($urandom);
         @(posedge clk); #1;
      end
      iv1 = 1'b0;
      check("pre_rst_ov16", 32'(ov1), 32'd1);
      rst_n = 1'b0;
      #1;
      check("arst_ov16", 32'(ov1), 32'd0);
      check("arst_sum16", 32'(s1), 32'd0);
      check("arst_cout16", 32'(co1), 32'd0);
      check("arst_ir16", 32'(ir1), 32'd1);
      q1.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      op1(16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0);
      check("post_rst_empty16", 32'(q1.size()), 32'd0);

      for (int cyc = 0; cyc < 24000; cyc++) begin
         iv2 = ($urandom_range(3) != 0);
         a2  = pick();
         b2  = pick();
         ci2 = 1'($urandom);
         sb2 = 1'($urandom);
         or2 = ($urandom_range(3) != 0);
         @(posedge clk); #1;
      end
      iv2 = 1'b0;
      or2 = 1'b1;
      for (int i = 0; i < 40 && (q2.size() != 0 || ov2); i++) begin
         @(posedge clk); #1;
      end
      check("drain32", 32'(q2.size()), 32'd0);
      check("ops32_min", 32'(n2 >= 10000), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "bench timed out");
   end

endmodule
